// File: rtl/nnrv_trace_buf_if.sv
// Commit-trace buffer bus: capture/trigger/readout requests in, readout data and status out.
interface nnrv_trace_buf_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            i_arm;
  logic            i_commit;
  logic [XLEN-1:0] i_pc;
  logic [31:0]     i_instr;
  logic            i_trig_en;
  logic [XLEN-1:0] i_trig_pc;
  logic            i_rd_req;

  logic            o_rd_valid;
  logic [XLEN-1:0] o_rd_pc;
  logic [31:0]     o_rd_instr;
  logic            o_rd_last;
  logic [1:0]      o_state;
  logic [CW-1:0]   o_count;
  logic            o_trig_seen;

  modport master (
    output i_arm, i_commit, i_pc, i_instr, i_trig_en, i_trig_pc, i_rd_req,
    input  o_rd_valid, o_rd_pc, o_rd_instr, o_rd_last, o_state, o_count, o_trig_seen
  );

  modport slave (
    input  i_arm, i_commit, i_pc, i_instr, i_trig_en, i_trig_pc, i_rd_req,
    output o_rd_valid, o_rd_pc, o_rd_instr, o_rd_last, o_state, o_count, o_trig_seen
  );
endinterface

// File: rtl/nnrv_trace_buf.sv
// Circular {pc, instr} commit-trace buffer with PC-match trigger, post-trigger window
// and oldest-first readout once frozen.
module nnrv_trace_buf #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  nnrv_trace_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, post_q;
  logic [CW-1:0]   count_q, remaining_q;
  logic            trig_seen_q, rd_valid_q, rd_last_q;
  logic [XLEN-1:0] rd_pc_q;
  logic [31:0]     rd_instr_q;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];

  logic            capture, trig_hit;
  logic [PW-1:0]   wr_ptr_d, frz_ptr_d;
  logic [CW-1:0]   count_d;

  // An arm in the same cycle wins over the commit, so it is never written.
  assign capture   = bus.i_commit & ~bus.i_arm & ((state_q == S_ARMED) || (state_q == S_POST));
  assign trig_hit  = bus.i_trig_en & (bus.i_pc == bus.i_trig_pc);
  assign wr_ptr_d  = wr_ptr_q + 1'b1;
  assign count_d   = (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
  assign frz_ptr_d = wr_ptr_d - count_d[PW-1:0];

  // NOTE: the trace RAM has no reset; clearing it would turn it into a flop array,
  // and stale entries are never read because count_q bounds the readout.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      mem_pc[wr_ptr_q]    <= bus.i_pc;
      mem_instr[wr_ptr_q] <= bus.i_instr;
    end
  end

  // NOTE: every state register uses <= so all of them update from the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_q      <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      trig_seen_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_pc_q     <= '0;
      rd_instr_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      if (bus.i_arm) begin
        state_q     <= S_ARMED;
        wr_ptr_q    <= '0;
        count_q     <= '0;
        remaining_q <= '0;
        trig_seen_q <= 1'b0;
      end else begin
        if (capture) begin
          wr_ptr_q <= wr_ptr_d;
          count_q  <= count_d;
        end
        unique case (state_q)
          S_ARMED: begin
            if (bus.i_commit && trig_hit) begin
              trig_seen_q <= 1'b1;
              if (POST_TRIG == 0) begin
                state_q     <= S_FROZEN;
                rd_ptr_q    <= frz_ptr_d;
                remaining_q <= count_d;
              end else begin
                state_q <= S_POST;
                post_q  <= PW'(POST_TRIG);
              end
            end
          end
          S_POST: begin
            if (bus.i_commit) begin
              post_q <= post_q - 1'b1;
              if (post_q == PW'(1)) begin
                state_q     <= S_FROZEN;
                rd_ptr_q    <= frz_ptr_d;
                remaining_q <= count_d;
              end
            end
          end
          S_FROZEN: begin
            if (bus.i_rd_req && (remaining_q != '0)) begin
              rd_valid_q  <= 1'b1;
              rd_last_q   <= (remaining_q == CW'(1));
              rd_pc_q     <= mem_pc[rd_ptr_q];
              rd_instr_q  <= mem_instr[rd_ptr_q];
              rd_ptr_q    <= rd_ptr_q + 1'b1;
              remaining_q <= remaining_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_state     = state_q;
  assign bus.o_count     = count_q;
  assign bus.o_trig_seen = trig_seen_q;
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_rd_last   = rd_last_q;
  assign bus.o_rd_pc     = rd_pc_q;
  assign bus.o_rd_instr  = rd_instr_q;
endmodule

// File: tb/tb_nnrv_trace_buf.sv
// Bench for nnrv_trace_buf: queue-level reference model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_nnrv_trace_buf;
  localparam int XLEN      = 32;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  nnrv_trace_buf_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  nnrv_trace_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  // Reference model: captured history as a queue, readout as a queue copy.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct packed {
    logic        last;
    logic [31:0] pc;
    logic [31:0] instr;
  } strobe_t;

  entry_t      m_buf[$];
  entry_t      m_rdq[$];
  logic [1:0]  m_state    = 2'd0;
  int          m_post     = 0;
  logic        m_trig     = 1'b0;
  logic        m_rd_valid = 1'b0;
  logic        m_rd_last  = 1'b0;
  logic [31:0] m_rd_pc    = '0;
  logic [31:0] m_rd_instr = '0;

  function automatic void m_capture();
    m_buf.push_back('{pc: bus.i_pc, instr: bus.i_instr});
    if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 2'd0; m_buf.delete(); m_rdq.delete(); m_trig = 1'b0;
      m_rd_valid = 1'b0; m_rd_last = 1'b0; m_rd_pc = '0; m_rd_instr = '0;
    end else begin
      m_rd_valid = 1'b0;
      m_rd_last  = 1'b0;
      if (bus.i_arm) begin
        m_state = 2'd1; m_buf.delete(); m_rdq.delete(); m_trig = 1'b0;
      end else if (m_state == 2'd1 && bus.i_commit) begin
        m_capture();
        if (bus.i_trig_en && bus.i_pc == bus.i_trig_pc) begin
          m_trig = 1'b1;
          if (POST_TRIG == 0) begin m_state = 2'd3; m_rdq = m_buf; end
          else begin m_state = 2'd2; m_post = POST_TRIG; end
        end
      end else if (m_state == 2'd2 && bus.i_commit) begin
        m_capture();
        m_post--;
        if (m_post == 0) begin m_state = 2'd3; m_rdq = m_buf; end
      end else if (m_state == 2'd3 && bus.i_rd_req && m_rdq.size() > 0) begin
        entry_t e;
        e = m_rdq.pop_front();
        m_rd_valid = 1'b1;
        m_rd_pc    = e.pc;
        m_rd_instr = e.instr;
        m_rd_last  = (m_rdq.size() == 0);
      end
    end
  end

  strobe_t strobes[$];

  always @(negedge clk) begin
    check("state",     64'(bus.o_state),     64'(m_state));
    check("count",     64'(bus.o_count),     64'(m_buf.size()));
    check("trig_seen", 64'(bus.o_trig_seen), 64'(m_trig));
    check("rd_valid",  64'(bus.o_rd_valid),  64'(m_rd_valid));
    check("rd_last",   64'(bus.o_rd_last),   64'(m_rd_last));
    check("rd_pc",     64'(bus.o_rd_pc),     64'(m_rd_pc));
    check("rd_instr",  64'(bus.o_rd_instr),  64'(m_rd_instr));
    if (bus.o_rd_valid)
      strobes.push_back('{last: bus.o_rd_last, pc: bus.o_rd_pc, instr: bus.o_rd_instr});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc);
    bus.i_commit = 1'b1;
    bus.i_pc     = pc;
    bus.i_instr  = instr_of(pc);
    tick();
    bus.i_commit = 1'b0;
  endtask

  task automatic arm();
    bus.i_arm = 1'b1;
    tick();
    bus.i_arm = 1'b0;
  endtask

  task automatic read_n(input int n);
    bus.i_rd_req = 1'b1;
    repeat (n) tick();
    bus.i_rd_req = 1'b0;
    tick();
  endtask

  initial begin
    bus.i_arm = 1'b0; bus.i_commit = 1'b0; bus.i_pc = '0; bus.i_instr = '0;
    bus.i_trig_en = 1'b0; bus.i_trig_pc = '0; bus.i_rd_req = 1'b0;

    // 1: reset, then commits/reads without arm are ignored
    #1 rst = 1'b1;
    #20;
    check("rst_state", 64'(bus.o_state), 64'd0);
    check("rst_count", 64'(bus.o_count), 64'd0);
    check("rst_rd_pc", 64'(bus.o_rd_pc), 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) commit(32'(k * 4));
    read_n(2);
    check("t1_state",   64'(bus.o_state), 64'd0);
    check("t1_count",   64'(bus.o_count), 64'd0);
    check("t1_strobes", 64'(strobes.size()), 64'd0);

    // 2: trigger at 0x10, three post commits, full ordered readout
    bus.i_trig_en = 1'b1; bus.i_trig_pc = 32'h10;
    arm();
    for (int k = 0; k < 8; k++) commit(32'(k * 4));
    check("t2_state", 64'(bus.o_state),     64'd3);
    check("t2_count", 64'(bus.o_count),     64'd8);
    check("t2_trig",  64'(bus.o_trig_seen), 64'd1);
    strobes.delete();
    read_n(8);
    check("t2_nstrobe", 64'(strobes.size()), 64'd8);
    for (int k = 0; k < 8 && k < strobes.size(); k++) begin
      check("t2_pc",   64'(strobes[k].pc),   64'(k * 4));
      check("t2_last", 64'(strobes[k].last), 64'(k == 7));
    end

    // 3: wrap, readout of the last eight commits 0x130..0x14C
    bus.i_trig_pc = 32'h140;
    arm();
    for (int k = 0; k < 20; k++) commit(32'h100 + 32'(k * 4));
    check("t3_state", 64'(bus.o_state), 64'd3);
    check("t3_count", 64'(bus.o_count), 64'd8);
    strobes.delete();
    read_n(8);
    check("t3_nstrobe", 64'(strobes.size()), 64'd8);
    if (strobes.size() == 8) begin
      check("t3_first_pc",    64'(strobes[0].pc),    64'h130);
      check("t3_first_instr", 64'(strobes[0].instr), 64'h5A5A_0130);
      check("t3_last_pc",     64'(strobes[7].pc),    64'h14C);
      check("t3_last_instr",  64'(strobes[7].instr), 64'h5A5A_014C);
      check("t3_last_flag",   64'(strobes[7].last),  64'd1);
    end

    // 4: trigger disabled, count saturates, stays ARMED
    bus.i_trig_en = 1'b0;
    arm();
    for (int k = 0; k < 30; k++) commit(32'(k * 4));
    check("t4_state", 64'(bus.o_state),     64'd1);
    check("t4_count", 64'(bus.o_count),     64'd8);
    check("t4_trig",  64'(bus.o_trig_seen), 64'd0);

    // 5: over-reading stops at eight; arm beats same-cycle read and commit
    bus.i_trig_en = 1'b1; bus.i_trig_pc = 32'h10;
    arm();
    for (int k = 0; k < 8; k++) commit(32'(k * 4));
    strobes.delete();
    read_n(10);
    check("t5_nstrobe", 64'(strobes.size()), 64'd8);
    if (strobes.size() == 8) check("t5_last", 64'(strobes[7].last), 64'd1);
    bus.i_arm = 1'b1; bus.i_rd_req = 1'b1; bus.i_commit = 1'b1;
    bus.i_pc = 32'h200; bus.i_instr = instr_of(32'h200);
    tick();
    bus.i_arm = 1'b0; bus.i_rd_req = 1'b0; bus.i_commit = 1'b0;
    tick();
    check("t5_state",   64'(bus.o_state), 64'd1);
    check("t5_count",   64'(bus.o_count), 64'd0);
    check("t5_nstrobe", 64'(strobes.size()), 64'd8);

    // 6: asynchronous reset in the middle of the post-trigger window
    for (int k = 0; k < 6; k++) commit(32'(k * 4));
    check("t6_post", 64'(bus.o_state), 64'd2);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_state", 64'(bus.o_state),     64'd0);
    check("t6_rst_count", 64'(bus.o_count),     64'd0);
    check("t6_rst_trig",  64'(bus.o_trig_seen), 64'd0);
    check("t6_rst_pc",    64'(bus.o_rd_pc),     64'd0);
    check("t6_rst_instr", 64'(bus.o_rd_instr),  64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) commit(32'h10);
    read_n(2);
    check("t6_idle_state", 64'(bus.o_state), 64'd0);
    check("t6_idle_count", 64'(bus.o_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nnrv_trace_buf.md
Name: nnrv_trace_buf

Overview:
- Synthesizable commit-trace capture buffer for the nnrv core.
- Records the {pc, instr} pair of every retired instruction into a circular buffer.
- Stops capturing a fixed number of commits after a PC-match trigger, then lets a debug agent or bench stream out the captured history, oldest entry first.
- Replaces per-cycle simulation printing with a hardware-resident, parametrised trace window.

Parameters:
- XLEN, 32: width of pc.
- DEPTH, 16: number of trace entries; power of two, minimum 2.
- POST_TRIG, 4: commits captured after the trigger entry; range 0..DEPTH-1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_arm  in  1  pulse: clear the buffer and start capturing
- i_commit  in  1  an instruction retires this cycle
- i_pc  in  XLEN  pc of the retiring instruction
- i_instr  in  32  encoding of the retiring instruction
- i_trig_en  in  1  enables PC-match trigger
- i_trig_pc  in  XLEN  trigger pc
- i_rd_req  in  1  request the next entry (honoured only in FROZEN)
- o_rd_valid  out  1  one-cycle strobe: read data valid
- o_rd_pc  out  XLEN  read pc
- o_rd_instr  out  32  read instruction
- o_rd_last  out  1  asserted with the final entry of the readout
- o_state  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3
- o_count  out  $clog2(DEPTH)+1  valid entries held, saturating at DEPTH
- o_trig_seen  out  1  trigger has fired since the last arm

Behaviour:
- Reset (asynchronous, immediate, any state): state IDLE, write pointer=0, o_count=0, o_trig_seen=0, o_rd_valid=0, o_rd_last=0, o_rd_pc=0, o_rd_instr=0. Buffer RAM contents are not reset.
- IDLE: i_commit and i_rd_req are ignored. i_arm moves the block to ARMED.
- i_arm in any state:
  - Next state ARMED; write pointer, o_count, o_trig_seen and the readout counter are cleared.
  - i_arm has priority over a same-cycle i_commit (that commit is not captured) and over i_rd_req (no strobe results).
- ARMED, on each i_commit:
  - Write {i_pc, i_instr} at the write pointer.
  - Advance the pointer modulo DEPTH; oldest entries are overwritten on wrap.
  - o_count increments, saturating at DEPTH.
- Trigger condition: i_trig_en & i_commit & (i_pc == i_trig_pc), while in ARMED.
  - The triggering entry is itself written.
  - o_trig_seen is set.
  - If POST_TRIG=0, go to FROZEN; otherwise go to POST with post counter = POST_TRIG.
- POST:
  - Each i_commit writes as in ARMED and decrements the post counter.
  - The commit that brings the counter to 0 is written, and the state moves to FROZEN on the same edge.
  - The trigger is not re-evaluated in POST.
- Entering FROZEN:
  - Read pointer = (write pointer after the final write − o_count) mod DEPTH, i.e. the oldest valid entry.
  - Remaining-read count = o_count.
  - o_count holds its value through readout.
- FROZEN:
  - i_commit is ignored.
  - i_rd_req with remaining > 0: on the next cycle o_rd_valid=1 with that entry, the read pointer advances, and remaining decrements.
  - o_rd_last=1 together with o_rd_valid on the entry that makes remaining 0.
  - Back-to-back requests are allowed: one entry per cycle, latency 1.
  - i_rd_req with remaining = 0 is ignored; o_rd_valid stays 0.
  - o_rd_pc and o_rd_instr hold their last value when o_rd_valid=0.
- Without a trigger the block stays in ARMED indefinitely; the buffer holds the last DEPTH commits.
- Width rules:
  - Trigger compare uses all XLEN bits.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - o_count is one bit wider than the pointers so it can represent DEPTH.

Test Plan:
- DEPTH=8, POST_TRIG=3 unless stated.
1. Reset, then 4 commits without arm -> o_state=0, o_count=0; any i_rd_req gives no o_rd_valid.
2. Arm; trig_pc=0x10; commit pcs 0x00,0x04,…,0x1C (8 commits) -> FROZEN after pc 0x1C, o_count=8, o_trig_seen=1; 8 rd_reqs return pcs 0x00..0x1C in order, o_rd_last only on 0x1C.
3. Wrap: arm; trig_pc=0x140; 20 commits at pc=0x100+4k (trigger at k=16, post k=17..19) -> o_count=8; readout pcs 0x130..0x14C, instr fields match.
4. i_trig_en=0 with 30 commits -> stays ARMED, o_count saturates at 8, o_trig_seen=0.
5. In FROZEN: 10 consecutive rd_reqs -> exactly 8 strobes, the last with o_rd_last; then i_arm together with i_rd_req and i_commit -> ARMED, o_count=0, no strobe, commit not captured.
6. Assert i_rst mid-POST (after 1 post commit) -> outputs drop to reset values without waiting for a clock edge; after release the block is IDLE until i_arm.
